cpu_core_param: RTL and testbench

Parametrised multi-cycle processor core, successor to the fixed 8-bit / 4-register lab CPU. Fetches instructions from an external instruction store over a request/valid handshake, executes a small register-register ISA with configurable data width, register count and address space, and exposes all architectural registers as a flattened output bus for display logic. A top-level wrapper instantiates it next to an instruction ROM or loader.

---
 rtl/cpu_core_param_if.sv | 12 +
 rtl/cpu_core_param.sv | 104 ++++++++++
 tb/tb_cpu_core_param.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_core_param_if.sv
// cpu_core_param_if: instruction fetch handshake between the core (master) and the instruction store (slave)
interface cpu_core_param_if #(
  parameter int PC_W = 6,
  parameter int INSTR_W = 18
);
  logic instr_req;
  logic [PC_W-1:0] instr_addr;
  logic instr_valid;
  logic [INSTR_W-1:0] instr;
  modport master(output instr_req, instr_addr, input instr_valid, instr);
  modport slave(input instr_req, instr_addr, output instr_valid, instr);
endinterface

// File: rtl/cpu_core_param.sv
// cpu_core_param: parametrised multi-cycle FETCH/EXEC/WB core with sticky signed overflow.
// Defining CPU_MUL_EN adds the signed MUL instruction (opcode 11); otherwise opcode 11 is a NOP.
module cpu_core_param #(
  parameter int DATA_W = 8,
  parameter int NUM_REGS = 4,
  parameter int IMEM_DEPTH = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic hold,
  cpu_core_param_if.master bus,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic ovf,
  output logic halted
);
  localparam int RA_W = $clog2(NUM_REGS);
  localparam int PC_W = $clog2(IMEM_DEPTH);
  localparam int INSTR_W = 4 + 3*RA_W + DATA_W;
  localparam int M = DATA_W - 1;
  localparam logic [1:0] FETCH = 2'd0, EXEC = 2'd1, WB = 2'd2, HALT = 2'd3;
  logic [1:0] state;
  logic [PC_W-1:0] pc;
  logic [INSTR_W-1:0] ir;
  logic [NUM_REGS-1:0][DATA_W-1:0] r;
  logic [3:0] op;
  logic [RA_W-1:0] rd, rs, rt;
  logic [DATA_W-1:0] imm, a, b, sum, diff, sumi, res, res_q;
  logic wen, vset, take, lt, wen_q, vset_q, take_q;
  assign {op, rd, rs, rt, imm} = ir;
  assign a = r[rs];
  assign b = r[rt];
  assign sum = a + b;
  assign diff = a - b;
  assign sumi = a + imm;
  assign lt = $signed(a) < $signed(b);
  assign take = (op == 4'd9) || (op == 4'd8 && a == b);
`ifdef CPU_MUL_EN
  logic signed [2*DATA_W-1:0] prod;
  assign prod = $signed(a) * $signed(b);
`endif
  // ALU result, write enable and overflow are settled in EXEC and committed in WB
  always_comb begin
    res = '0;
    wen = 1'b0;
    vset = 1'b0;
    case (op)
      4'd1: begin res = sum; wen = 1'b1; vset = (a[M] == b[M]) && (sum[M] != a[M]); end
      4'd2: begin res = diff; wen = 1'b1; vset = (a[M] != b[M]) && (diff[M] != a[M]); end
      4'd3: begin res = a & b; wen = 1'b1; end
      4'd4: begin res = a | b; wen = 1'b1; end
      4'd5: begin res = imm; wen = 1'b1; end
      4'd6: begin res = a; wen = 1'b1; end
      4'd7: begin res = {{M{1'b0}}, lt}; wen = 1'b1; end
      4'd10: begin res = sumi; wen = 1'b1; vset = (a[M] == imm[M]) && (sumi[M] != a[M]); end
`ifdef CPU_MUL_EN
      4'd11: begin
        res = prod[M:0];
        wen = 1'b1;
        vset = prod != {{DATA_W{prod[M]}}, prod[M:0]};
      end
`endif
      default: ;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
      pc <= '0;
      ir <= '0;
      r <= '0;
      ovf <= 1'b0;
      halted <= 1'b0;
      res_q <= '0;
      wen_q <= 1'b0;
      vset_q <= 1'b0;
      take_q <= 1'b0;
    end else if (!hold) begin
      case (state)
        FETCH: if (bus.instr_valid) begin
          ir <= bus.instr;
          state <= EXEC;
        end
        EXEC: begin
          res_q <= res;
          wen_q <= wen;
          vset_q <= vset;
          take_q <= take;
          halted <= op == 4'hf;
          state <= op == 4'hf ? HALT : WB;
        end
        WB: begin
          if (wen_q) r[rd] <= res_q;
          ovf <= ovf | vset_q;
          pc <= take_q ? imm[PC_W-1:0] : pc + PC_W'(1);
          state <= FETCH;
        end
        default: ;
      endcase
    end
  end
  assign bus.instr_req = state == FETCH && !hold;
  assign bus.instr_addr = pc;
  assign regs_flat = r;
endmodule

// File: tb/tb_cpu_core_param.sv
// tb_cpu_core_param: directed and randomized checks of cpu_core_param against an ISA-level reference model
module tb_cpu_core_param;
  localparam int DW = 8, NR = 4, DEPTH = 64, PW = 6, IW = 18;
  logic clk = 1'b0;
  logic reset, hold;
  logic [NR*DW-1:0] regs_flat;
  logic ovf, halted;
  cpu_core_param_if #(.PC_W(PW), .INSTR_W(IW)) bus();
  cpu_core_param #(.DATA_W(DW), .NUM_REGS(NR), .IMEM_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .hold(hold), .bus(bus),
    .regs_flat(regs_flat), .ovf(ovf), .halted(halted)
  );
  always #5 clk = ~clk;
  logic [IW-1:0] imem [DEPTH];
  int mr [NR];
  int mpc;
  bit movf, mhalt;
  int tests = 0, fails = 0;

  function automatic logic [IW-1:0] enc(int op, int rd, int rs, int rt, int imm);
    return {4'(op), 2'(rd), 2'(rs), 2'(rt), 8'(imm)};
  endfunction

  function automatic int wrap(int v);
    int t;
    t = v & 255;
    return t > 127 ? t - 256 : t;
  endfunction

  function automatic logic [NR*DW-1:0] model_flat();
    logic [NR*DW-1:0] f;
    for (int i = 0; i < NR; i++) f[i*DW +: DW] = DW'(mr[i]);
    return f;
  endfunction

  // ISA semantics with integer arithmetic; overflow means leaving [-128,127]
  task automatic model_step(input logic [IW-1:0] ins);
    int op, rd, a, b, imm, raw, v, npc;
    op = int'(ins[17:14]);
    rd = int'(ins[13:12]);
    a = mr[int'(ins[11:10])];
    b = mr[int'(ins[9:8])];
    raw = int'(ins[7:0]);
    imm = wrap(raw);
    npc = (mpc + 1) % DEPTH;
    case (op)
      1: begin v = a + b; if (v > 127 || v < -128) movf = 1; mr[rd] = wrap(v); end
      2: begin v = a - b; if (v > 127 || v < -128) movf = 1; mr[rd] = wrap(v); end
      3: mr[rd] = wrap(a & b);
      4: mr[rd] = wrap(a | b);
      5: mr[rd] = imm;
      6: mr[rd] = a;
      7: mr[rd] = a < b ? 1 : 0;
      8: if (a == b) npc = raw % DEPTH;
      9: npc = raw % DEPTH;
      10: begin v = a + imm; if (v > 127 || v < -128) movf = 1; mr[rd] = wrap(v); end
`ifdef CPU_MUL_EN
      11: begin v = a * b; if (v > 127 || v < -128) movf = 1; mr[rd] = wrap(v); end
`endif
      15: mhalt = 1;
      default: ;
    endcase
    if (op != 15) mpc = npc;
  endtask

  task automatic clear_imem();
    for (int i = 0; i < DEPTH; i++) imem[i] = enc(15, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    hold = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr = '0;
    for (int i = 0; i < NR; i++) mr[i] = 0;
    mpc = 0;
    movf = 0;
    mhalt = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bus.instr = imem[bus.instr_addr];
  endtask

  task automatic tick();
    @(negedge clk);
    bus.instr = imem[bus.instr_addr];
  endtask

  // random valid/hold driver; every accepted fetch is checked against the model first
  task automatic run_prog(input int maxc, input int pv, input int ph);
    int c;
    c = 0;
    while (!(mhalt && halted) && c < maxc) begin
      @(negedge clk);
      hold = $urandom_range(99) < ph;
      bus.instr_valid = $urandom_range(99) < pv;
      #1;
      if (hold) begin
        tests++;
        if (bus.instr_req !== 1'b0) begin fails++; $display("FAIL hold_req: instr_req=%b required 0", bus.instr_req); end
      end
      if (bus.instr_req && bus.instr_valid) begin
        bus.instr = imem[bus.instr_addr];
        tests += 4;
        if (mhalt) begin fails++; $display("FAIL accept_after_halt: fetch at %0d after HALT", bus.instr_addr); end
        if (bus.instr_addr !== PW'(mpc)) begin fails++; $display("FAIL fetch_addr: got %0d required %0d", bus.instr_addr, mpc); end
        if (regs_flat !== model_flat()) begin fails++; $display("FAIL regs: got %h required %h", regs_flat, model_flat()); end
        if (ovf !== movf) begin fails++; $display("FAIL ovf: got %b required %b", ovf, movf); end
        model_step(bus.instr);
      end else bus.instr = IW'($urandom);
      c++;
    end
    hold = 1'b0;
    bus.instr_valid = 1'b0;
    tests += 3;
    if (!(mhalt && halted)) begin fails++; $display("FAIL timeout: halted=%b model_halt=%b after %0d cycles", halted, mhalt, c); end
    if (regs_flat !== model_flat()) begin fails++; $display("FAIL final_regs: got %h required %h", regs_flat, model_flat()); end
    if (ovf !== movf) begin fails++; $display("FAIL final_ovf: got %b required %b", ovf, movf); end
  endtask

  task automatic test_reset();
    clear_imem();
    imem[0] = enc(5, 1, 0, 0, -7);
    do_reset();
    bus.instr_valid = 1'b1;
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    tests += 6;
    if (regs_flat !== '0) begin fails++; $display("FAIL reset_regs: got %h required 0", regs_flat); end
    if (ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b required 0", ovf); end
    if (halted !== 1'b0) begin fails++; $display("FAIL reset_halted: got %b required 0", halted); end
    if (bus.instr_addr !== '0) begin fails++; $display("FAIL reset_addr: got %0d required 0", bus.instr_addr); end
    if (bus.instr_req !== 1'b1) begin fails++; $display("FAIL reset_req: got %b required 1", bus.instr_req); end
    hold = 1'b1;
    #1;
    if (bus.instr_req !== 1'b0) begin fails++; $display("FAIL reset_req_hold: got %b required 0", bus.instr_req); end
    do_reset();
    tick();
    tests++;
    if (regs_flat !== '0) begin fails++; $display("FAIL abort_write: got %h required 0", regs_flat); end
  endtask

  task automatic test_add();
    clear_imem();
    imem[0] = enc(5, 1, 0, 0, 5);
    imem[1] = enc(5, 2, 0, 0, -3);
    imem[2] = enc(1, 3, 1, 2, 0);
    do_reset();
    bus.instr_valid = 1'b1;
    tests++;
    if (bus.instr_addr !== 6'd0) begin fails++; $display("FAIL add_addr0: got %0d required 0", bus.instr_addr); end
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k % 3 == 0) begin
        tests++;
        if (bus.instr_addr !== PW'(k / 3)) begin fails++; $display("FAIL add_addr%0d: got %0d required %0d", k, bus.instr_addr, k / 3); end
      end
      if (k == 8) begin
        tests++;
        if (regs_flat[3*DW +: DW] !== 8'd0) begin fails++; $display("FAIL add_early: r3=%h required 00", regs_flat[3*DW +: DW]); end
      end
    end
    tests += 4;
    if (regs_flat[3*DW +: DW] !== 8'd2) begin fails++; $display("FAIL add_r3: got %h required 02", regs_flat[3*DW +: DW]); end
    if (regs_flat[1*DW +: DW] !== 8'd5) begin fails++; $display("FAIL add_r1: got %h required 05", regs_flat[1*DW +: DW]); end
    if (regs_flat[2*DW +: DW] !== 8'hfd) begin fails++; $display("FAIL add_r2: got %h required fd", regs_flat[2*DW +: DW]); end
    if (ovf !== 1'b0) begin fails++; $display("FAIL add_ovf: got %b required 0", ovf); end
  endtask

  task automatic test_ovf();
    clear_imem();
    imem[0] = enc(5, 1, 0, 0, 127);
    imem[1] = enc(10, 2, 1, 0, 1);
    imem[2] = enc(5, 1, 0, 0, 0);
    do_reset();
    run_prog(400, 60, 0);
    tests += 3;
    if (regs_flat[2*DW +: DW] !== 8'h80) begin fails++; $display("FAIL ovf_r2: got %h required 80", regs_flat[2*DW +: DW]); end
    if (regs_flat[1*DW +: DW] !== 8'h00) begin fails++; $display("FAIL ovf_r1: got %h required 00", regs_flat[1*DW +: DW]); end
    if (ovf !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b required 1", ovf); end
  endtask

  task automatic test_branch();
    for (int t = 0; t < 2; t++) begin
      clear_imem();
      imem[0] = enc(5, 1, 0, 0, 4);
      imem[1] = enc(5, 2, 0, 0, t == 0 ? 4 : 3);
      imem[2] = enc(8, 0, 1, 2, 10);
      imem[3] = enc(15, 0, 0, 0, 0);
      do_reset();
      run_prog(400, 70, 10);
      tests++;
      if (bus.instr_addr !== PW'(t == 0 ? 10 : 3)) begin fails++; $display("FAIL beq_target%0d: got %0d required %0d", t, bus.instr_addr, t == 0 ? 10 : 3); end
    end
  endtask

  task automatic test_wrap_halt();
    clear_imem();
    imem[0] = enc(9, 0, 0, 0, 63);
    imem[63] = enc(0, 0, 0, 0, 0);
    do_reset();
    bus.instr_valid = 1'b1;
    repeat (3) tick();
    tests++;
    if (bus.instr_addr !== 6'd63) begin fails++; $display("FAIL jmp_addr: got %0d required 63", bus.instr_addr); end
    imem[0] = enc(15, 0, 0, 0, 0);
    repeat (3) tick();
    tests++;
    if (bus.instr_addr !== 6'd0) begin fails++; $display("FAIL wrap_addr: got %0d required 0", bus.instr_addr); end
    repeat (2) tick();
    imem[0] = enc(5, 2, 0, 0, 55);
    for (int k = 0; k < 20; k++) begin
      tick();
      tests += 4;
      if (halted !== 1'b1) begin fails++; $display("FAIL halt_flag%0d: got %b required 1", k, halted); end
      if (bus.instr_req !== 1'b0) begin fails++; $display("FAIL halt_req%0d: got %b required 0", k, bus.instr_req); end
      if (regs_flat !== '0) begin fails++; $display("FAIL halt_regs%0d: got %h required 0", k, regs_flat); end
      if (bus.instr_addr !== 6'd0) begin fails++; $display("FAIL halt_addr%0d: got %0d required 0", k, bus.instr_addr); end
    end
  endtask

  task automatic test_hold();
    clear_imem();
    imem[0] = enc(5, 1, 0, 0, 5);
    imem[1] = enc(5, 2, 0, 0, -3);
    imem[2] = enc(1, 3, 1, 2, 0);
    do_reset();
    bus.instr_valid = 1'b1;
    tick();
    hold = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      tests++;
      if (bus.instr_req !== 1'b0) begin fails++; $display("FAIL hold_exec_req%0d: got %b required 0", k, bus.instr_req); end
      tick();
    end
    hold = 1'b0;
    tick();
    tests++;
    if (bus.instr_addr !== 6'd0) begin fails++; $display("FAIL hold_addr_n7: got %0d required 0", bus.instr_addr); end
    tick();
    tests += 2;
    if (bus.instr_addr !== 6'd1) begin fails++; $display("FAIL hold_addr_n8: got %0d required 1", bus.instr_addr); end
    if (regs_flat[1*DW +: DW] !== 8'd5) begin fails++; $display("FAIL hold_r1: got %h required 05", regs_flat[1*DW +: DW]); end
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests++;
      if (bus.instr_req !== 1'b0) begin fails++; $display("FAIL hold_fetch_req%0d: got %b required 0", k, bus.instr_req); end
      tick();
    end
    hold = 1'b0;
    tests++;
    if (bus.instr_addr !== 6'd1) begin fails++; $display("FAIL hold_no_accept: addr %0d required 1", bus.instr_addr); end
    repeat (3) tick();
    tests += 2;
    if (bus.instr_addr !== 6'd2) begin fails++; $display("FAIL hold_addr_n14: got %0d required 2", bus.instr_addr); end
    if (regs_flat[2*DW +: DW] !== 8'hfd) begin fails++; $display("FAIL hold_r2: got %h required fd", regs_flat[2*DW +: DW]); end
    repeat (2) tick();
    tests++;
    if (regs_flat[3*DW +: DW] !== 8'd0) begin fails++; $display("FAIL hold_r3_early: got %h required 00", regs_flat[3*DW +: DW]); end
    tick();
    tests += 2;
    if (regs_flat[3*DW +: DW] !== 8'd2) begin fails++; $display("FAIL hold_r3: got %h required 02", regs_flat[3*DW +: DW]); end
    if (bus.instr_addr !== 6'd3) begin fails++; $display("FAIL hold_addr_n17: got %0d required 3", bus.instr_addr); end
  endtask

  task automatic test_mul();
    for (int t = 0; t < 2; t++) begin
      clear_imem();
      imem[0] = enc(5, 3, 0, 0, 11);
      imem[1] = enc(5, 1, 0, 0, t == 0 ? -6 : 16);
      imem[2] = enc(5, 2, 0, 0, t == 0 ? 7 : 16);
      imem[3] = enc(11, 3, 1, 2, 0);
      do_reset();
      run_prog(400, 80, 10);
      tests += 2;
`ifdef CPU_MUL_EN
      if (regs_flat[3*DW +: DW] !== (t == 0 ? 8'hd6 : 8'h00)) begin fails++; $display("FAIL mul_r3_%0d: got %h", t, regs_flat[3*DW +: DW]); end
      if (ovf !== (t == 1)) begin fails++; $display("FAIL mul_ovf_%0d: got %b required %b", t, ovf, t == 1); end
`else
      if (regs_flat[3*DW +: DW] !== 8'd11) begin fails++; $display("FAIL mul_nop_r3_%0d: got %h required 0b", t, regs_flat[3*DW +: DW]); end
      if (ovf !== 1'b0) begin fails++; $display("FAIL mul_nop_ovf_%0d: got %b required 0", t, ovf); end
`endif
    end
  endtask

  task automatic test_random();
    int op, imm;
    for (int p = 0; p < 6; p++) begin
      clear_imem();
      for (int a = 0; a < 48; a++) begin
        op = $urandom_range(14);
        imm = $urandom_range(255);
        if (op == 8 || op == 9) imm = a + 1 + $urandom_range(3);
        imem[a] = enc(op, $urandom_range(3), $urandom_range(3), $urandom_range(3), imm);
      end
      do_reset();
      run_prog(2000, 70, 20);
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_ovf();
    test_branch();
    test_wrap_halt();
    test_hold();
    test_mul();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
